// File: rtl/sa_tile_scheduler.sv
// Tile-loop scheduler for a systolic matmul core: walks (m, n, k) with k innermost,
// handshakes each tile with the core and presents registered buffer base addresses.
module sa_tile_scheduler #(
    parameter int I_SIZE = 256,
    parameter int W_SIZE = 256,
    parameter int O_SIZE = 256,
    parameter int I_TILE = 16,
    parameter int W_TILE = 16,
    parameter int O_TILE = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      cfg_valid_i,
    output logic                      cfg_ready_o,
    input  logic [7:0]                cfg_m_i,
    input  logic [7:0]                cfg_n_i,
    input  logic [7:0]                cfg_k_i,
    input  logic                      abort_i,
    output logic                      mm_start_o,
    input  logic                      mm_done_i,
    output logic                      mm_acc_o,
    output logic [$clog2(I_SIZE)-1:0] ib_base_o,
    output logic [$clog2(W_SIZE)-1:0] wb_base_o,
    output logic [$clog2(O_SIZE)-1:0] ob_base_o,
    output logic [7:0]                tile_m_o,
    output logic [7:0]                tile_n_o,
    output logic [7:0]                tile_k_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      aborted_o
);
    localparam int IA = $clog2(I_SIZE);
    localparam int WA = $clog2(W_SIZE);
    localparam int OA = $clog2(O_SIZE);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_RELEASE, S_ADVANCE} state_e;

    state_e          state_q, state_d;
    logic [7:0]      m_q, m_d, n_q, n_d, k_q, k_d;
    logic [7:0]      cm_q, cm_d, cn_q, cn_d, ck_q, ck_d;
    logic [IA-1:0]   ib_q, ib_d;
    logic [WA-1:0]   wb_q, wb_d;
    logic [OA-1:0]   ob_q, ob_d;
    logic            acc_q, acc_d;
    logic            done_q, done_d, err_q, err_d, abt_q, abt_d;
    logic            last_tile;

    assign last_tile = (m_q == cm_q - 8'd1) && (n_q == cn_q - 8'd1) && (k_q == ck_q - 8'd1);

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        n_d     = n_q;
        k_d     = k_q;
        cm_d    = cm_q;
        cn_d    = cn_q;
        ck_d    = ck_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        abt_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid_i) begin
                    if ((cfg_m_i != 8'd0) && (cfg_n_i != 8'd0) && (cfg_k_i != 8'd0)) begin
                        cm_d    = cfg_m_i;
                        cn_d    = cfg_n_i;
                        ck_d    = cfg_k_i;
                        m_d     = 8'd0;
                        n_d     = 8'd0;
                        k_d     = 8'd0;
                        state_d = S_START;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_START:   state_d = S_WAIT;
            S_WAIT:    if (mm_done_i) state_d = S_RELEASE;
            S_RELEASE: if (!mm_done_i) state_d = S_ADVANCE;
            S_ADVANCE: begin
                if (last_tile) begin
                    done_d  = 1'b1;
                    m_d     = 8'd0;
                    n_d     = 8'd0;
                    k_d     = 8'd0;
                    state_d = S_IDLE;
                end else begin
                    if (k_q == ck_q - 8'd1) begin
                        k_d = 8'd0;
                        if (n_q == cn_q - 8'd1) begin
                            n_d = 8'd0;
                            m_d = m_q + 8'd1;
                        end else begin
                            n_d = n_q + 8'd1;
                        end
                    end else begin
                        k_d = k_q + 8'd1;
                    end
                    state_d = S_START;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything, including a last-tile completion in the same cycle.
        if (state_q != S_IDLE && abort_i) begin
            state_d = S_IDLE;
            abt_d   = 1'b1;
            done_d  = 1'b0;
            m_d     = 8'd0;
            n_d     = 8'd0;
            k_d     = 8'd0;
        end
    end

    // Bases follow the next indices so they change only when the indices do.
    always_comb begin
        ib_d  = IA'((32'(m_d) * 32'(ck_d) + 32'(k_d)) * 32'(I_TILE));
        wb_d  = WA'((32'(n_d) * 32'(ck_d) + 32'(k_d)) * 32'(W_TILE));
        ob_d  = OA'((32'(m_d) * 32'(cn_d) + 32'(n_d)) * 32'(O_TILE));
        acc_d = (k_d != 8'd0);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
            cm_q    <= '0;
            cn_q    <= '0;
            ck_q    <= '0;
            ib_q    <= '0;
            wb_q    <= '0;
            ob_q    <= '0;
            acc_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            abt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            n_q     <= n_d;
            k_q     <= k_d;
            cm_q    <= cm_d;
            cn_q    <= cn_d;
            ck_q    <= ck_d;
            ib_q    <= ib_d;
            wb_q    <= wb_d;
            ob_q    <= ob_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            err_q   <= err_d;
            abt_q   <= abt_d;
        end
    end

    assign cfg_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign mm_start_o  = (state_q == S_START) || (state_q == S_WAIT);
    assign mm_acc_o    = acc_q;
    assign ib_base_o   = ib_q;
    assign wb_base_o   = wb_q;
    assign ob_base_o   = ob_q;
    assign tile_m_o    = m_q;
    assign tile_n_o    = n_q;
    assign tile_k_o    = k_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign aborted_o   = abt_q;

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Scoreboard bench: stimulus pushes model tiles/events, a negedge monitor pops and compares.
module tb_sa_tile_scheduler;
    localparam int IT = 16, WT = 16, OT = 16;
    localparam logic [2:0] EV_DONE = 3'b100, EV_ABT = 3'b010, EV_ERR = 3'b001;

    logic       clk = 1'b0;
    logic       rstn;
    logic       cfg_valid, cfg_ready;
    logic [7:0] cfg_m, cfg_n, cfg_k;
    logic       abort, mm_start, mm_done, mm_acc;
    logic [7:0] ib_base, wb_base, ob_base, tile_m, tile_n, tile_k;
    logic       busy, done, err, aborted;

    sa_tile_scheduler dut (
        .clk_i(clk), .rstn_i(rstn), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_m_i(cfg_m), .cfg_n_i(cfg_n), .cfg_k_i(cfg_k), .abort_i(abort),
        .mm_start_o(mm_start), .mm_done_i(mm_done), .mm_acc_o(mm_acc),
        .ib_base_o(ib_base), .wb_base_o(wb_base), .ob_base_o(ob_base),
        .tile_m_o(tile_m), .tile_n_o(tile_n), .tile_k_o(tile_k),
        .busy_o(busy), .done_o(done), .err_o(err), .aborted_o(aborted)
    );

    always #5 clk = ~clk;

    typedef struct { int m, n, k, ib, wb, ob, acc; } tile_t;
    tile_t      exp_q[$];
    logic [2:0] evt_q[$];
    int         errors = 0, checks = 0, starts = 0;
    int         dly_lo = 1, dly_hi = 6, hold_lo = 0, hold_hi = 2;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain nested loops, k innermost, addresses from the formulas.
    task automatic push_job(input int M, input int N, input int K, input int limit);
        tile_t t;
        int c = 0;
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++)
                for (int k = 0; k < K; k++) begin
                    if (c < limit) begin
                        t.m = m; t.n = n; t.k = k;
                        t.ib = ((m * K + k) * IT) % 256;
                        t.wb = ((n * K + k) * WT) % 256;
                        t.ob = ((m * N + n) * OT) % 256;
                        t.acc = (k != 0) ? 1 : 0;
                        exp_q.push_back(t);
                    end
                    c++;
                end
    endtask

    task automatic cmp_tile(input string w, input tile_t e);
        chk({w, ".m"}, tile_m, e.m);
        chk({w, ".n"}, tile_n, e.n);
        chk({w, ".k"}, tile_k, e.k);
        chk({w, ".ib"}, ib_base, e.ib);
        chk({w, ".wb"}, wb_base, e.wb);
        chk({w, ".ob"}, ob_base, e.ob);
        chk({w, ".acc"}, mm_acc, e.acc);
    endtask

    // Monitor: tile values checked at start rise and again in RELEASE (stability).
    tile_t      cur;
    logic       prev_start = 1'b0;
    logic [2:0] ev;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_start = 1'b0;
        end else begin
            if (mm_start && !prev_start) begin
                starts++;
                if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
                else begin
                    cur = exp_q.pop_front();
                    cmp_tile("start", cur);
                end
            end else if (!mm_start && prev_start && busy) begin
                cmp_tile("release", cur);
            end
            ev = {done, aborted, err};
            if (ev != 3'b000) begin
                if (evt_q.size() == 0) chk("unexpected_event", int'(ev), 0);
                else chk("event", int'(ev), int'(evt_q.pop_front()));
            end
            prev_start = mm_start;
        end
    end

    // Core model: raise done after a delay, hold it for a while after start drops.
    int c_d, c_t, c_h;
    initial begin
        mm_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn && mm_start) begin
                c_d = $urandom_range(dly_hi, dly_lo);
                c_t = 0;
                while (c_t < c_d && mm_start) begin
                    @(negedge clk);
                    c_t++;
                end
                if (mm_start) begin
                    mm_done = 1'b1;
                    c_t = 0;
                    while (mm_start && c_t < 1000) begin
                        @(negedge clk);
                        c_t++;
                    end
                    if (c_t >= 1000) chk("core_release_timeout", c_t, 0);
                    c_h = $urandom_range(hold_hi, hold_lo);
                    for (int i = 0; i < c_h; i++) begin
                        @(negedge clk);
                        if (rstn) chk("hold_no_restart", mm_start, 0);
                    end
                    mm_done = 1'b0;
                end
            end
        end
    end

    task automatic issue(input int M, input int N, input int K, input int exp_busy);
        @(negedge clk);
        cfg_m = 8'(M); cfg_n = 8'(N); cfg_k = 8'(K); cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("accept_busy", busy, exp_busy);
        chk("accept_ready", cfg_ready, 1 - exp_busy);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int t = 0;
        while ((evt_q.size() != 0 || exp_q.size() != 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk({nm, ".pending"}, evt_q.size() + exp_q.size(), 0);
        @(negedge clk);
        chk({nm, ".ready"}, cfg_ready, 1);
        chk({nm, ".busy"}, busy, 0);
    endtask

    task automatic wait_starts(input int target, input int budget);
        int t = 0;
        while (starts < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("starts_reached", (starts >= target) ? 1 : 0, 1);
    endtask

    task automatic job(input string nm, input int M, input int N, input int K);
        push_job(M, N, K, M * N * K);
        evt_q.push_back(EV_DONE);
        issue(M, N, K, 1);
        wait_idle(nm, M * N * K * (dly_hi + hold_hi + 8) + 50);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int s0;
    initial begin
        rstn = 1'b0; cfg_valid = 1'b0; cfg_m = '0; cfg_n = '0; cfg_k = '0; abort = 1'b0;
        #12;
        chk("rst.ready", cfg_ready, 1);
        chk("rst.busy", busy, 0);
        chk("rst.start", mm_start, 0);
        chk("rst.pulses", int'({done, err, aborted}), 0);
        chk("rst.acc", mm_acc, 0);
        chk("rst.bases", int'({ib_base, wb_base, ob_base}), 0);
        chk("rst.tile", int'({tile_m, tile_n, tile_k}), 0);
        @(negedge clk); rstn = 1'b1;

        // Single tile, core answers 5 cycles after start.
        dly_lo = 5; dly_hi = 5;
        job("single", 1, 1, 1);

        dly_lo = 1; dly_hi = 6;
        job("m2n2k3", 2, 2, 3);

        // Zero counts are rejected with an error pulse.
        evt_q.push_back(EV_ERR);
        issue(2, 3, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("zero.start", mm_start, 0);
            chk("zero.busy", busy, 0);
        end
        evt_q.push_back(EV_ERR);
        issue(0, 1, 1, 0);
        wait_idle("zero_m", 10);

        // Abort in IDLE does nothing.
        @(negedge clk); abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        chk("idle_abort.busy", busy, 0);
        chk("idle_abort.ready", cfg_ready, 1);

        // Abort during WAIT of tile 3 of 6.
        dly_lo = 8; dly_hi = 8;
        s0 = starts;
        push_job(1, 2, 3, 3);
        evt_q.push_back(EV_ABT);
        issue(1, 2, 3, 1);
        wait_starts(s0 + 3, 100);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort.start", mm_start, 0);
        chk("abort.busy", busy, 0);
        wait_idle("abort", 20);
        dly_lo = 1; dly_hi = 4;
        job("after_abort", 1, 1, 2);

        // cfg_valid held through a job; done held 3 cycles in RELEASE.
        hold_lo = 3; hold_hi = 3;
        s0 = starts;
        push_job(1, 2, 2, 4);
        evt_q.push_back(EV_DONE);
        push_job(1, 2, 2, 4);
        evt_q.push_back(EV_DONE);
        @(negedge clk);
        cfg_m = 8'd1; cfg_n = 8'd2; cfg_k = 8'd2; cfg_valid = 1'b1;
        @(negedge clk);
        chk("held.ready", cfg_ready, 0);
        wait_starts(s0 + 2, 100);
        chk("held.ready_mid", cfg_ready, 0);
        wait_starts(s0 + 5, 200);
        cfg_valid = 1'b0;
        wait_idle("held", 200);
        hold_lo = 0; hold_hi = 2;

        // Random small jobs.
        for (int r = 0; r < 4; r++)
            job("rand", $urandom_range(3, 1), $urandom_range(3, 1), $urandom_range(3, 1));

        // Reduced large-count runs: address wrap modulo 256.
        dly_lo = 1; dly_hi = 1; hold_hi = 0;
        job("wrap_k255", 2, 2, 255);
        job("wrap_m255", 255, 1, 1);
        dly_hi = 4; hold_hi = 2;

        // Reset mid-job: start drops immediately, no pulse follows.
        s0 = starts;
        push_job(2, 2, 3, 12);
        evt_q.push_back(EV_DONE);
        issue(2, 2, 3, 1);
        wait_starts(s0 + 4, 200);
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        chk("midrst.start", mm_start, 0);
        chk("midrst.busy", busy, 0);
        chk("midrst.ready", cfg_ready, 1);
        chk("midrst.tile_k", tile_k, 0);
        exp_q.delete();
        evt_q.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst.idle", busy, 0);
        job("after_reset", 1, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sa_tile_scheduler.md
SA_TILE_SCHEDULER -- requirements
Module: sa_tile_scheduler

Interface
REQ-001 SHALL have parameter I_SIZE, default 256: input buffer depth in words; address width IA = $clog2(I_SIZE).
REQ-002 SHALL have parameter W_SIZE, default 256: weight buffer depth in words; address width WA = $clog2(W_SIZE).
REQ-003 SHALL have parameter O_SIZE, default 256: output buffer depth in words; address width OA = $clog2(O_SIZE).
REQ-004 SHALL have parameters I_TILE, W_TILE, O_TILE, each default 16: words per input, weight and output tile.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rstn_i, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have ports cfg_valid_i (input, 1) and cfg_ready_o (output, 1): job handshake.
REQ-008 SHALL have ports cfg_m_i, cfg_n_i and cfg_k_i, each input, 8 bits: tile counts M, N and K.
REQ-009 SHALL have port abort_i, input, 1 bit: cancel the running job.
REQ-010 SHALL have port mm_start_o, output, 1 bit: start level to the matmul core.
REQ-011 SHALL have port mm_done_i, input, 1 bit: done level from the matmul core.
REQ-012 SHALL have port mm_acc_o, output, 1 bit: accumulate into partial sums.
REQ-013 SHALL have ports ib_base_o (IA bits), wb_base_o (WA bits) and ob_base_o (OA bits), all outputs: tile base addresses.
REQ-014 SHALL have ports tile_m_o, tile_n_o and tile_k_o, each output, 8 bits: current tile indices m, n, k.
REQ-015 SHALL have ports busy_o, done_o, err_o and aborted_o, each output, 1 bit: status.

Function
REQ-016 SHALL implement FSM states IDLE, START, WAIT, RELEASE, ADVANCE.
REQ-017 IDLE: cfg_ready_o=1; on cfg_valid_i=1 with M, N and K all nonzero, SHALL latch M, N and K, clear m, n and k to 0, and enter START.
REQ-018 IDLE with cfg_valid_i=1 and any count equal to 0: SHALL pulse err_o for 1 cycle and stay in IDLE.
REQ-019 START: mm_start_o=1; SHALL go to WAIT next cycle (mm_start_o rises 1 cycle after the accepting edge).
REQ-020 WAIT: mm_start_o held at 1 until mm_done_i=1 is sampled, then SHALL go to RELEASE.
REQ-021 RELEASE: mm_start_o=0; SHALL stay until mm_done_i=0 is sampled, then go to ADVANCE.
REQ-022 ADVANCE: SHALL increment k; on k wrap (k=K-1) clear k and increment n; on n wrap clear n and increment m.
REQ-023 ADVANCE: SHALL go to START unless the last tile (m=M-1, n=N-1, k=K-1) has completed.
REQ-024 After the last tile, ADVANCE SHALL pulse done_o for 1 cycle and return to IDLE.
REQ-025 Loop order SHALL be k innermost, then n, then m.
REQ-026 mm_acc_o SHALL equal (k != 0) whenever busy_o=1.
REQ-027 ib_base_o SHALL equal ((m*K + k)*I_TILE) mod 2^IA.
REQ-028 wb_base_o SHALL equal ((n*K + k)*W_TILE) mod 2^WA.
REQ-029 ob_base_o SHALL equal ((m*N + n)*O_TILE) mod 2^OA.
REQ-030 Base addresses, tile indices and mm_acc_o SHALL be registered and stable from START through RELEASE of each tile.
REQ-031 busy_o SHALL be 1 in every state except IDLE; cfg_ready_o SHALL be 0 while busy_o=1, and cfg_valid_i SHALL be ignored then.
REQ-032 abort_i=1 in any non-IDLE state SHALL force mm_start_o=0 the next cycle, pulse aborted_o for 1 cycle, and return to IDLE without done_o.
REQ-033 abort_i and last-tile completion in the same cycle: abort SHALL win (aborted_o=1, done_o=0).
REQ-034 abort_i in IDLE SHALL have no effect.
REQ-035 mm_done_i=1 sampled in START or IDLE SHALL be ignored.

Reset
REQ-036 rstn_i=0 SHALL asynchronously force state IDLE and clear all counters and latched counts.
REQ-037 During reset, every output SHALL be 0 except cfg_ready_o, which SHALL be 1.
REQ-038 Reset asserted mid-job SHALL drop mm_start_o immediately, and no done_o or aborted_o pulse SHALL follow.

Verification
REQ-039 M=1, N=1, K=1, core done 5 cycles after start -> exactly one start; bases 0/0/0; mm_acc_o=0; done_o pulses once; cfg_ready_o returns to 1.
REQ-040 M=2, N=2, K=3, I_TILE=W_TILE=O_TILE=16 -> 12 starts in order (0,0,0)...(1,1,2); tile (1,1,2) gives ib=80, wb=80, ob=48, mm_acc_o=1.
REQ-041 cfg with K=0 -> err_o 1-cycle pulse; mm_start_o stays 0; busy_o stays 0.
REQ-042 abort_i during WAIT of tile 3 of 6 -> mm_start_o 0 next cycle; aborted_o pulse; no done_o; new job then accepted.
REQ-043 cfg_valid_i held high during a job -> ignored until IDLE; mm_done_i held high 3 cycles in RELEASE -> no advance until it falls.
REQ-044 M=N=K=255, I_SIZE=256 -> ib_base_o wraps modulo 256; done_o after 255^3 tiles (reduced-count smoke run allowed).
